// File: rtl/vpl_alu_ctrl_if.sv
// rtl/vpl_alu_ctrl_if.sv - command, ALU and status bundle for the ALU controller
interface vpl_alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_func;
  logic [3:0] cmd_operand;
  logic [1:0] cmd_repeat;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_func;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic [3:0] acc;
  logic       carry;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_load, cmd_func, cmd_operand, cmd_repeat,
    output alu_result, alu_cout,
    input  cmd_ready, alu_a, alu_b, alu_func, acc, carry, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_func, cmd_operand, cmd_repeat,
    input  alu_result, alu_cout,
    output cmd_ready, alu_a, alu_b, alu_func, acc, carry, busy, done
  );
endinterface

// File: rtl/vpl_alu_ctrl.sv
// rtl/vpl_alu_ctrl.sv - accumulator controller sequencing an external 4-bit combinational ALU
module vpl_alu_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  vpl_alu_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_acc;
  logic       r_carry;
  logic [1:0] r_cnt;
  logic [3:0] r_func;
  logic [3:0] r_opb;
  logic       w_accept;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  // State register; reset aborts any operation in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: loads go straight to DONE, ops iterate in EXEC until cnt reaches zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = bus.cmd_load ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 2'd0) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: command capture on accept, accumulator/carry update once per EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 4'd0;
      r_carry <= 1'b0;
      r_cnt   <= 2'd0;
      r_func  <= 4'd0;
      r_opb   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.cmd_load) begin
              r_acc   <= bus.cmd_operand;
              r_carry <= 1'b0;
            end else begin
              r_func <= bus.cmd_func;
              r_opb  <= bus.cmd_operand;
              r_cnt  <= bus.cmd_repeat;
            end
          end
        end
        S_EXEC: begin
          // carry reflects only the latest iteration
          r_acc   <= bus.alu_result;
          r_carry <= bus.alu_cout;
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ALU drive: live operands only while executing, neutral function otherwise
  always_comb begin
    bus.alu_a    = r_acc;
    bus.alu_b    = 4'd0;
    bus.alu_func = 4'd0;
    if (r_state == S_EXEC) begin
      bus.alu_b    = r_opb;
      bus.alu_func = r_func;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.acc       = r_acc;
  assign bus.carry     = r_carry;

endmodule
